pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It is the successor to the fixed two-word stall/flush stage latch and is usable between any pair of pipeline stages (IF/ID, ID/EX, ...). It carries NCH data words plus sideband bits and supports synchronous flush to a NOP value. Its input ready is fully registered, so no combinational path runs from downstream ready to upstream ready. It also keeps a saturating count of back-pressure cycles for performance debug.

---
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_skid_reg.sv | 103 ++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline stage with two-entry skid buffer, flush-to-NOP and stall counter
module pipe_skid_reg #(
  parameter int          DW       = 32,
  parameter int          NCH      = 2,
  parameter int          SB_W     = 1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic [SB_W-1:0]     in_sb,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NCH*DW-1:0]   out_data,
  output logic [SB_W-1:0]     out_sb,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    stall_cnt,
  input  logic                stall_clr
);
  localparam logic [DW-1:0]     NOP     = DW'(NOP_WORD);
  localparam logic [NCH*DW-1:0] NOP_ALL = {NCH{NOP}};
  logic                main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
  logic [NCH*DW-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [SB_W-1:0]     main_sb_q, main_sb_d, skid_sb_q, skid_sb_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic                in_fire, out_fire;
  assign in_fire   = in_valid & rdy_q;
  assign out_fire  = main_v_q & out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign out_sb    = main_sb_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign stall_cnt = stall_q;
  // Entry movement: flush kills everything, otherwise skid drains first so order stays FIFO
  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
    main_sb_d   = main_sb_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_sb_d   = skid_sb_q;
    rdy_d       = rdy_q;
    if (flush) begin
      main_v_d    = 1'b0;
      main_data_d = NOP_ALL;
      main_sb_d   = '0;
      skid_v_d    = 1'b0;
      skid_data_d = NOP_ALL;
      skid_sb_d   = '0;
      rdy_d       = 1'b1;
    end else if (skid_v_q) begin
      if (out_fire) begin
        main_data_d = skid_data_q;
        main_sb_d   = skid_sb_q;
        skid_v_d    = 1'b0;
        rdy_d       = 1'b1;
      end
    end else if (!main_v_q || out_fire) begin
      main_v_d = in_fire;
      if (in_fire) begin
        main_data_d = in_data;
        main_sb_d   = in_sb;
      end
    end else if (in_fire) begin
      skid_v_d    = 1'b1;
      skid_data_d = in_data;
      skid_sb_d   = in_sb;
      rdy_d       = 1'b0;
    end
  end
  // Back-pressure counter: clear wins, otherwise saturating increment on a held entry
  always_comb begin
    stall_d = stall_clr ? '0 :
              (main_v_q && !out_ready && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  end
  // State registers; in_ready lives in its own flop so it never depends on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q    <= 1'b0;
      main_data_q <= NOP_ALL;
      main_sb_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= NOP_ALL;
      skid_sb_q   <= '0;
      rdy_q       <= 1'b1;
      stall_q     <= '0;
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
      main_sb_q   <= main_sb_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_sb_q   <= skid_sb_d;
      rdy_q       <= rdy_d;
      stall_q     <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: table-driven and directed checks for pipe_skid_reg
module tb_pipe_skid_reg;
  localparam logic [31:0] NOPW = 32'hDEAD_BEEF;
  localparam logic [63:0] NOPV = {NOPW, NOPW};
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, stall_clr = 1'b0;
  logic in_ready, out_valid;
  logic [63:0] in_data = '0, out_data;
  logic [0:0] in_sb = '0, out_sb;
  logic [1:0] occupancy;
  logic [3:0] stall_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic fl, iv;
    logic [63:0] d;
    logic sb, ordy, clr, ov, ir;
    logic [63:0] od;
    logic osb;
    logic [1:0] occ;
    logic [3:0] sc;
  } vec_t;
  vec_t v[$];
  pipe_skid_reg #(.DW(32), .NCH(2), .SB_W(1), .NOP_WORD(NOPW), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sb(in_sb), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sb(out_sb), .occupancy(occupancy), .stall_cnt(stall_cnt),
    .stall_clr(stall_clr)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mk(input logic [7:0] d);
    return {24'h000100 + 32'(d), 24'h0 , d};
  endfunction
  task automatic add(input logic fl, iv, input logic [63:0] d, input logic sb, ordy, clr,
                     input logic ov, ir, input logic [63:0] od, input logic osb,
                     input logic [1:0] occ, input logic [3:0] sc);
    v.push_back('{fl, iv, d, sb, ordy, clr, ov, ir, od, osb, occ, sc});
  endtask
  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h expected %h", name, idx, got, exp);
    end
  endtask
  task automatic chk_all(input int idx, input logic ov, ir, input logic [63:0] od,
                         input logic osb, input logic [1:0] occ, input logic [3:0] sc);
    chk("out_valid", idx, 64'(out_valid), 64'(ov));
    chk("in_ready", idx, 64'(in_ready), 64'(ir));
    chk("out_data", idx, out_data, od);
    chk("out_sb", idx, 64'(out_sb), 64'(osb));
    chk("occupancy", idx, 64'(occupancy), 64'(occ));
    chk("stall_cnt", idx, 64'(stall_cnt), 64'(sc));
  endtask
  initial begin
    for (int i = 1; i <= 8; i++)
      add(0, 1, mk(8'(i)), i[0], 1, 0, 1, 1, mk(8'(i)), i[0], 1, 0);
    add(0, 0, mk(8'h00), 0, 1, 0, 0, 1, mk(8'h08), 0, 0, 0);
    add(0, 1, mk(8'h11), 1, 0, 0, 1, 1, mk(8'h11), 1, 1, 0);
    add(0, 1, mk(8'h22), 0, 0, 0, 1, 0, mk(8'h11), 1, 2, 1);
    add(0, 1, mk(8'h33), 1, 0, 0, 1, 0, mk(8'h11), 1, 2, 2);
    add(0, 0, mk(8'h00), 0, 1, 0, 1, 1, mk(8'h22), 0, 1, 2);
    add(0, 0, mk(8'h00), 0, 1, 0, 0, 1, mk(8'h22), 0, 0, 2);
    add(0, 0, mk(8'h00), 0, 0, 1, 0, 1, mk(8'h22), 0, 0, 0);
    add(0, 1, mk(8'h44), 1, 0, 0, 1, 1, mk(8'h44), 1, 1, 0);
    add(0, 1, mk(8'h55), 0, 0, 0, 1, 0, mk(8'h44), 1, 2, 1);
    add(1, 1, mk(8'h66), 1, 0, 0, 0, 1, NOPV, 0, 0, 2);
    add(0, 1, mk(8'h77), 1, 0, 0, 1, 1, mk(8'h77), 1, 1, 2);
    add(1, 1, mk(8'h88), 1, 1, 0, 0, 1, NOPV, 0, 0, 2);
    add(0, 0, mk(8'h00), 0, 1, 0, 0, 1, NOPV, 0, 0, 2);
    add(0, 1, mk(8'h99), 1, 0, 0, 1, 1, mk(8'h99), 1, 1, 2);
    for (int i = 1; i <= 20; i++)
      add(0, 0, mk(8'h00), 0, 0, 0, 1, 1, mk(8'h99), 1, 1, (2 + i > 15) ? 4'd15 : 4'(2 + i));
    add(0, 0, mk(8'h00), 0, 0, 1, 1, 1, mk(8'h99), 1, 1, 0);
    add(0, 0, mk(8'h00), 0, 0, 0, 1, 1, mk(8'h99), 1, 1, 1);
    add(0, 0, mk(8'h00), 0, 1, 0, 0, 1, mk(8'h99), 1, 0, 1);
    repeat (2) @(posedge clk);
    #1 chk_all(-1, 0, 1, NOPV, 0, 0, 0);
    rst_n = 1'b1;
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].d; in_sb = v[i].sb;
      out_ready = v[i].ordy; stall_clr = v[i].clr;
      @(posedge clk);
      #1 chk_all(i, v[i].ov, v[i].ir, v[i].od, v[i].osb, v[i].occ, v[i].sc);
    end
    flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(8'hA1); in_sb = 1'b1;
    @(posedge clk);
    in_data = mk(8'hA2); in_sb = 1'b0;
    @(posedge clk);
    #1 chk("occ before reset", 100, 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all(101, 0, 1, NOPV, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = mk(8'hAB); in_sb = 1'b1;
    @(posedge clk);
    #1 chk_all(102, 1, 1, mk(8'hAB), 1, 1, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk_all(103, 0, 1, mk(8'hAB), 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
